ahb_sram_if: RTL and testbench

AHB_SRAM_IF -- requirements
Module: ahb_sram_if

---
 rtl/ahb_sram_if.sv | 190 +++++++++++++++++++
 tb/tb_ahb_sram_if.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_if.sv
// ahb_sram_if -- AHB-Lite slave that fronts four byte-lane synchronous SRAM banks.
//
// Reads are issued to the SRAM combinationally in the address phase, so the
// synchronous SRAM output arrives in the data phase with no wait states.
// Writes are issued in the data phase, when hwdata is valid. A read that
// directly follows a write finds the SRAM port busy, so it is held for one
// cycle (RD_STALL) and then issued.
//
// Bus handshake: a transfer is offered when hsel & htrans[1] are high and is
// taken on the rising edge where hready is also high. hreadyout low stretches
// the current data phase, and the master must hold its next address phase.
//
// Optional feature, enabled by defining SRAMC_ERR_RESP_EN: transfers taken
// while bist_en=1, or with hsize>2, get a two-cycle ERROR response. When the
// macro is undefined, hresp is always OKAY, hsize>2 is handled as a word
// access, and transfers taken during BIST are silently dropped.
//
// dbg_state_o exposes the FSM state for checkers.
module ahb_sram_if (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hready,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        bist_en,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [12:0] sram_addr,
  output logic [3:0]  sram_cen,
  output logic [3:0]  sram_wen,
  output logic        sram_oen,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_RD_STALL = 3'd3
`ifdef SRAMC_ERR_RESP_EN
    ,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] addr_q, addr_d;   // write word address, or stalled read address
  logic [3:0]  mask_q, mask_d;   // write lane mask
  logic [2:0]  size_q, size_d;   // write transfer size

  logic        accept;
  logic        blocked;
  logic [3:0]  lane_mask;

  // Reset gates acceptance so no address-phase read can leak out during reset.
  assign accept = hresetn & hsel & hready & htrans[1];

`ifdef SRAMC_ERR_RESP_EN
  assign blocked = bist_en | (hsize > 3'd2);
`else
  assign blocked = bist_en;
`endif

  assign dbg_state_o = state_q;

  // Upper address bits alias, htrans[0] (SEQ vs NONSEQ) does not matter,
  // and the registered size is kept for observability only.
  logic unused_sigs;
  assign unused_sigs = ^{haddr[31:15], htrans[0], size_q};

  // Byte-lane mask from transfer size and low address bits.
  always_comb begin
    lane_mask = 4'hF;
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'hF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pipeline registers holding the pending SRAM access.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q <= '0;
      mask_q <= '0;
      size_q <= '0;
    end else begin
      addr_q <= addr_d;
      mask_q <= mask_d;
      size_q <= size_d;
    end
  end

  // Data-phase outputs from the current state, then address-phase decode
  // that picks the next state and may issue a read immediately.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    size_d     = size_q;
    hreadyout  = 1'b1;
    hresp      = 2'b00;
    hrdata     = '0;
    sram_cen   = 4'hF;
    sram_wen   = 4'hF;
    sram_oen   = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;

    case (state_q)
      ST_WR_DATA: begin
        sram_cen   = ~mask_q;
        sram_wen   = ~mask_q;
        sram_addr  = addr_q;
        sram_wdata = hwdata;
      end
      ST_RD_STALL: begin
        hreadyout = 1'b0;
        sram_cen  = 4'h0;
        sram_oen  = 1'b0;
        sram_addr = addr_q;
      end
      ST_RD_DATA: begin
        hrdata = sram_rdata;
      end
`ifdef SRAMC_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
      end
      ST_ERR2: begin
        hresp = 2'b01;
      end
`endif
      default: begin
      end
    endcase

    if (state_q == ST_RD_STALL) begin
      state_d = ST_RD_DATA;
    end
`ifdef SRAMC_ERR_RESP_EN
    else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end
`endif
    else if (!accept) begin
      state_d = ST_IDLE;
    end else if (blocked) begin
`ifdef SRAMC_ERR_RESP_EN
      state_d = ST_ERR1;
`else
      state_d = ST_IDLE;
`endif
    end else if (hwrite) begin
      state_d = ST_WR_DATA;
      addr_d  = haddr[14:2];
      mask_d  = lane_mask;
      size_d  = hsize;
    end else if (state_q == ST_WR_DATA) begin
      // SRAM port is busy with the write data phase: hold the read.
      state_d = ST_RD_STALL;
      addr_d  = haddr[14:2];
    end else begin
      state_d   = ST_RD_DATA;
      sram_cen  = 4'h0;
      sram_wen  = 4'hF;
      sram_oen  = 1'b0;
      sram_addr = haddr[14:2];
    end
  end

endmodule

// File: tb/tb_ahb_sram_if.sv
// tb_ahb_sram_if -- directed bench for ahb_sram_if (default build).
// A behavioural SRAM sits on the memory port; a transaction-level model of
// the bus (reference memory plus the data phase in flight) predicts every
// output on every cycle, and a few literal expectations pin the model.
module tb_ahb_sram_if;

  // ---------------- clock / reset / signals ----------------
  logic        hclk    = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel    = 1'b0;
  logic        hwrite  = 1'b0;
  logic [1:0]  htrans  = 2'b00;
  logic [2:0]  hsize   = 3'd0;
  logic [31:0] haddr   = 32'h0;
  logic [31:0] hwdata  = 32'h0;
  logic        bist_en = 1'b0;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [12:0] sram_addr;
  logic [3:0]  sram_cen;
  logic [3:0]  sram_wen;
  logic        sram_oen;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;
  logic [2:0]  dbg_state;

  always #5 hclk = ~hclk;

  // Single slave on the bus: the bus ready is this slave's ready.
  assign hready = hreadyout;

  ahb_sram_if dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel),
    .hready      (hready),
    .hwrite      (hwrite),
    .htrans      (htrans),
    .hsize       (hsize),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .bist_en     (bist_en),
    .hreadyout   (hreadyout),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .sram_addr   (sram_addr),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_oen    (sram_oen),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .dbg_state_o (dbg_state)
  );

  // ---------------- behavioural SRAM ----------------
  logic [31:0] smem    [0:8191];
  logic [31:0] ref_mem [0:8191];

  always @(posedge hclk) begin
    for (int i = 0; i < 4; i++) begin
      if (!sram_cen[i] && !sram_wen[i]) smem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
    if (!sram_oen && sram_cen == 4'h0 && sram_wen == 4'hF) sram_rdata <= smem[sram_addr];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | i;
  endfunction

  // Byte lanes touched by an access: 2^size bytes, naturally aligned.
  function automatic logic [3:0] lanes_of(input logic [1:0] a, input logic [2:0] sz);
    int nbytes;
    int first;
    nbytes = (sz > 3'd2) ? 4 : (1 << sz);
    first  = int'(a) & ~(nbytes - 1);
    return 4'(((1 << nbytes) - 1) << first);
  endfunction

  // ---------------- model + compare (every cycle) ----------------
  // dp_kind: 0 = no data phase work, 1 = performed write, 2 = performed read
  int          dp_kind = 0;
  int          dp_wait = 0;
  logic [12:0] dp_word = '0;
  logic [3:0]  dp_lanes = '0;

  always @(negedge hclk) begin
    logic [31:0] e_rdata, e_wdata;
    logic [3:0]  e_cen, e_wen;
    logic        e_oen, e_rdy, acc, prev_wr;
    logic [12:0] e_addr;
    e_rdata = 32'h0; e_wdata = 32'h0; e_cen = 4'hF; e_wen = 4'hF;
    e_oen = 1'b1; e_rdy = 1'b1; e_addr = 13'h0;
    acc = hresetn && hsel && hready && htrans[1];
    if (hresetn) begin
      if (dp_kind == 1) begin
        e_cen = ~dp_lanes; e_wen = ~dp_lanes; e_addr = dp_word; e_wdata = hwdata;
      end else if (dp_kind == 2 && dp_wait > 0) begin
        e_rdy = 1'b0; e_cen = 4'h0; e_oen = 1'b0; e_addr = dp_word;
      end else if (dp_kind == 2) begin
        e_rdata = ref_mem[dp_word];
      end
      if (acc && !bist_en && !hwrite && dp_kind != 1 && !(dp_kind == 2 && dp_wait > 0)) begin
        e_cen = 4'h0; e_wen = 4'hF; e_oen = 1'b0; e_addr = haddr[14:2];
      end
    end
    chk("hreadyout", 32'(hreadyout), 32'(e_rdy));
    chk("hresp", 32'(hresp), 32'h0);
    chk("hrdata", hrdata, e_rdata);
    chk("sram_cen", 32'(sram_cen), 32'(e_cen));
    chk("sram_wen", 32'(sram_wen), 32'(e_wen));
    chk("sram_oen", 32'(sram_oen), 32'(e_oen));
    chk("sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("sram_wdata", sram_wdata, e_wdata);
    // Advance the model to the state after the coming rising edge.
    if (!hresetn) begin
      dp_kind = 0;
      dp_wait = 0;
    end else if (dp_kind == 2 && dp_wait > 0) begin
      dp_wait--;
    end else begin
      prev_wr = (dp_kind == 1);
      if (prev_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (dp_lanes[i]) ref_mem[dp_word][8*i +: 8] = hwdata[8*i +: 8];
        end
      end
      if (!acc || bist_en) begin
        dp_kind = 0;
      end else if (hwrite) begin
        dp_kind  = 1;
        dp_word  = haddr[14:2];
        dp_lanes = lanes_of(haddr[1:0], hsize);
      end else begin
        dp_kind = 2;
        dp_word = haddr[14:2];
        dp_wait = prev_wr ? 1 : 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] pend_wd    = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic [3:0]  last_cen   = 4'h0;
  logic [12:0] last_saddr = 13'h0;
  int          last_stalls = 0;

  // Hold the current address phase until the slave is ready; records what
  // the data phase ending on the taking edge showed.
  task automatic wait_ready();
    logic rdy;
    for (int n = 0; n < 20; n++) begin
      @(negedge hclk);
      rdy        = hreadyout;
      last_rdata = hrdata;
      last_cen   = sram_cen;
      last_saddr = sram_addr;
      @(posedge hclk);
      #1;
      if (rdy) begin
        last_stalls = n;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout actual=hreadyout_low required=high_within_20 at %0t", $time);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic bist);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    bist_en = bist; hwdata = pend_wd;
    wait_ready();
    pend_wd = wr ? wd : 32'h0;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; bist_en = 1'b0; hwdata = pend_wd;
    wait_ready();
    pend_wd = 32'h0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 8192; i++) begin
      smem[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    // Reset with a read address phase on the bus: nothing may be issued.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_cen", 32'(sram_cen), 32'hF);
    chk("rst_oen", 32'(sram_oen), 32'h1);
    chk("rst_hreadyout", 32'(hreadyout), 32'h1);
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hresetn = 1'b1;

    // Word write then read back after an idle: zero wait states.
    xfer(1'b1, 32'h10, 3'd2, 32'hA5A5_5A5A, 1'b0);
    idle();
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    idle();
    chk("rd10_stalls", 32'(last_stalls), 32'd0);
    chk("rd10_data", last_rdata, 32'hA5A5_5A5A);

    // Byte write 0x77 at 0x13 lands in lane 3 of word 4.
    xfer(1'b1, 32'h13, 3'd0, 32'h7700_0000, 1'b0);
    hsel = 1'b0; htrans = 2'b00; hwdata = pend_wd;
    @(negedge hclk);
    chk("bw_cen", 32'(sram_cen), 32'h7);
    chk("bw_wen", 32'(sram_wen), 32'h7);
    chk("bw_addr", 32'(sram_addr), 32'h004);
    @(posedge hclk);
    #1;
    pend_wd = 32'h0;
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    idle();
    chk("bw_readback", last_rdata, 32'h77A5_5A5A);

    // Write then immediate read of the same word: exactly one wait state.
    xfer(1'b1, 32'h20, 3'd2, 32'h1234_5678, 1'b0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
    idle();
    chk("wr_rd_stalls", 32'(last_stalls), 32'd1);
    chk("wr_rd_data", last_rdata, 32'h1234_5678);

    // Four back-to-back word writes: no stalls, word addresses 0..3.
    xfer(1'b1, 32'h0, 3'd2, 32'h1111_1111, 1'b0);
    xfer(1'b1, 32'h4, 3'd2, 32'h2222_2222, 1'b0);
    chk("b2b_addr0", 32'(last_saddr), 32'd0);
    xfer(1'b1, 32'h8, 3'd2, 32'h3333_3333, 1'b0);
    chk("b2b_addr1", 32'(last_saddr), 32'd1);
    xfer(1'b1, 32'hC, 3'd2, 32'h4444_4444, 1'b0);
    chk("b2b_addr2", 32'(last_saddr), 32'd2);
    idle();
    chk("b2b_addr3", 32'(last_saddr), 32'd3);
    chk("b2b_stalls", 32'(last_stalls), 32'd0);
    for (int k = 0; k < 4; k++) xfer(1'b0, 32'(4 * k), 3'd2, 32'h0, 1'b0);
    idle();
    chk("b2b_read3", last_rdata, 32'h4444_4444);

    // Halfword to the upper half of word 8, then hsize=3 handled as a word.
    xfer(1'b1, 32'h22, 3'd1, 32'hBEEF_0000, 1'b0);
    idle();
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
    idle();
    chk("hw_readback", last_rdata, 32'hBEEF_5678);
    xfer(1'b1, 32'h24, 3'd3, 32'hCAFE_F00D, 1'b0);
    idle();
    xfer(1'b0, 32'h24, 3'd2, 32'h0, 1'b0);
    idle();
    chk("sz3_readback", last_rdata, 32'hCAFE_F00D);

    // Upper address bits alias.
    xfer(1'b1, 32'h0001_8044, 3'd2, 32'h0BAD_F00D, 1'b0);
    idle();
    xfer(1'b0, 32'h44, 3'd2, 32'h0, 1'b0);
    idle();
    chk("alias_readback", last_rdata, 32'h0BAD_F00D);

    // BIST owns the arrays: read and write are dropped.
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 1'b1);
    chk("bist_rd_cen_ap", 32'(last_cen), 32'hF);
    idle();
    chk("bist_rd_cen_dp", 32'(last_cen), 32'hF);
    chk("bist_rd_data", last_rdata, 32'h0);
    xfer(1'b1, 32'h40, 3'd2, 32'hFFFF_FFFF, 1'b1);
    idle();
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 1'b0);
    idle();
    chk("bist_wr_dropped", last_rdata, 32'hC0DE_0010);

    // Read, then write from the read data phase, then read it back.
    xfer(1'b0, 32'h0, 3'd2, 32'h0, 1'b0);
    xfer(1'b1, 32'h8, 3'd2, 32'h5555_AAAA, 1'b0);
    chk("rd_wr_stalls", 32'(last_stalls), 32'd0);
    xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0);
    idle();
    chk("rd_wr_rd_data", last_rdata, 32'h5555_AAAA);

    // Reset pulse during a write data phase: the write must not happen.
    xfer(1'b1, 32'h30, 3'd2, 32'hDEAD_BEEF, 1'b0);
    hsel = 1'b0; htrans = 2'b00; hwdata = pend_wd; hresetn = 1'b0;
    @(negedge hclk);
    chk("rstwr_cen", 32'(sram_cen), 32'hF);
    chk("rstwr_wen", 32'(sram_wen), 32'hF);
    chk("rstwr_addr", 32'(sram_addr), 32'h0);
    chk("rstwr_wdata", sram_wdata, 32'h0);
    chk("rstwr_hreadyout", 32'(hreadyout), 32'h1);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    pend_wd = 32'h0;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, 1'b0);
    idle();
    chk("rstwr_stalls", 32'(last_stalls), 32'd0);
    chk("rstwr_readback", last_rdata, 32'hC0DE_000C);

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit in case a wait is never satisfied.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished at %0t", $time);
    $fatal(1);
  end

endmodule
